// File: rtl/lcm_pkg.sv
// Shared constants and state encoding for the lcm stage.
// Optional remainder check is enabled by defining LCM_DIVCHECK_EN.
package lcm_pkg;

   localparam int W_DEF = 8;
   localparam int CNT_W = $clog2(W_DEF) + 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DIV  = 3'd1,
      MUL  = 3'd2,
      FAST = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/lcm_unit_seq_divider.sv
// W-cycle restoring divider: first quotient bit is formed on the start edge,
// the remaining W-1 bits on the following edges; done pulses with q/r final.
module seq_divider
   import lcm_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
`ifdef LCM_DIVCHECK_EN
   output logic [W-1:0] r,
`endif
   output logic         done,
   output logic [W-1:0] q
);

   localparam int CW = $clog2(W) + 1;

   logic [W-1:0]  rem_r;
   logic [W-1:0]  quo_r;
   logic [W-1:0]  dvs_r;
   logic [CW-1:0] cnt_r;
   logic          busy_r;
   logic          done_r;

   logic [W-1:0]  rem_in_s;
   logic [W-1:0]  quo_in_s;
   logic [W-1:0]  dvs_in_s;
   logic [W:0]    trial_s;
   logic [W:0]    diff_s;
   logic          qbit_s;
   logic [W-1:0]  rem_next_s;
   logic [W-1:0]  quo_next_s;

   // One restoring step; a missing borrow means the divisor fits.
   always_comb begin
      rem_in_s = rem_r;
      quo_in_s = quo_r;
      dvs_in_s = dvs_r;
      if (start) begin
         rem_in_s = {W{1'b0}};
         quo_in_s = dividend;
         dvs_in_s = divisor;
      end else begin
         rem_in_s = rem_r;
         quo_in_s = quo_r;
         dvs_in_s = dvs_r;
      end
      trial_s    = {rem_in_s, quo_in_s[W-1]};
      diff_s     = trial_s - {1'b0, dvs_in_s};
      qbit_s     = ~diff_s[W];
      rem_next_s = qbit_s ? diff_s[W-1:0] : trial_s[W-1:0];
      quo_next_s = {quo_in_s[W-2:0], qbit_s};
   end

   // Step sequencing and done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_r  <= {W{1'b0}};
         quo_r  <= {W{1'b0}};
         dvs_r  <= {W{1'b0}};
         cnt_r  <= {CW{1'b0}};
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (start) begin
            rem_r  <= rem_next_s;
            quo_r  <= quo_next_s;
            dvs_r  <= dvs_in_s;
            cnt_r  <= CW'(W - 1);
            busy_r <= 1'b1;
         end else if (busy_r) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end else begin
               busy_r <= 1'b1;
            end
         end else begin
            busy_r <= 1'b0;
         end
      end
   end

   assign done = done_r;
   assign q    = quo_r;
`ifdef LCM_DIVCHECK_EN
   assign r    = rem_r;
`endif

endmodule

// File: rtl/lcm_unit.sv
// lcm = (a / g) * b via sequential divide then shift-add multiply.
// Define LCM_DIVCHECK_EN to flag a nonzero remainder of a / g through err.
module lcm_unit
   import lcm_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [W-1:0]   g,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] lcm,
   output logic           err
);

   localparam int CW = $clog2(W) + 1;

   state_t          state_r;
   logic [W-1:0]    b_r;
   logic [W-1:0]    mq_r;
   logic [2*W-1:0]  mb_r;
   logic [2*W-1:0]  acc_r;
   logic [CW-1:0]   cnt_r;
   logic            ferr_r;

   logic            accept_s;
   logic            zero_s;
   logic            start_s;
   logic            div_done_s;
   logic [W-1:0]    div_q_s;
   logic [2*W-1:0]  acc_next_s;
   logic            rem_err_s;
`ifdef LCM_DIVCHECK_EN
   logic [W-1:0]    div_r_s;
`endif

   assign accept_s   = in_valid & in_ready;
   assign zero_s     = (a == {W{1'b0}}) | (b == {W{1'b0}});
   assign start_s    = accept_s & ~zero_s & (g != {W{1'b0}});
   assign acc_next_s = mq_r[0] ? (acc_r + mb_r) : acc_r;

   // Remainder check only exists when the optional feature is built in.
   always_comb begin
`ifdef LCM_DIVCHECK_EN
      rem_err_s = (div_r_s != {W{1'b0}});
`else
      rem_err_s = 1'b0;
`endif
   end

   seq_divider #(.W(W)) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (start_s),
      .dividend (a),
      .divisor  (g),
`ifdef LCM_DIVCHECK_EN
      .r        (div_r_s),
`endif
      .done     (div_done_s),
      .q        (div_q_s)
   );

   // Control FSM with the inline shift-add multiplier and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         b_r       <= {W{1'b0}};
         mq_r      <= {W{1'b0}};
         mb_r      <= {(2*W){1'b0}};
         acc_r     <= {(2*W){1'b0}};
         cnt_r     <= {CW{1'b0}};
         ferr_r    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         lcm       <= {(2*W){1'b0}};
         err       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  in_ready <= 1'b0;
                  b_r      <= b;
                  if (zero_s) begin
                     state_r <= FAST;
                     ferr_r  <= 1'b0;
                  end else if (g == {W{1'b0}}) begin
                     state_r <= FAST;
                     ferr_r  <= 1'b1;
                  end else begin
                     state_r <= DIV;
                     ferr_r  <= 1'b0;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            DIV: begin
               if (div_done_s) begin
                  state_r <= MUL;
                  mq_r    <= div_q_s;
                  mb_r    <= {{W{1'b0}}, b_r};
                  acc_r   <= {(2*W){1'b0}};
                  cnt_r   <= {CW{1'b0}};
               end else begin
                  state_r <= DIV;
               end
            end
            MUL: begin
               acc_r <= acc_next_s;
               mq_r  <= {1'b0, mq_r[W-1:1]};
               mb_r  <= {mb_r[2*W-2:0], 1'b0};
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == CW'(W - 1)) begin
                  state_r   <= DONE;
                  out_valid <= 1'b1;
                  lcm       <= acc_next_s;
                  err       <= rem_err_s;
               end else begin
                  state_r <= MUL;
               end
            end
            FAST: begin
               state_r   <= DONE;
               out_valid <= 1'b1;
               lcm       <= {(2*W){1'b0}};
               err       <= ferr_r;
            end
            DONE: begin
               if (out_ready) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcm_unit.sv
// Directed self-checking bench for lcm_unit (W=8).
module tb_lcm_unit;

   localparam int W = 8;

   logic           clk;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [W-1:0]   g;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] lcm;
   logic           err;

   int compared   = 0;
   int mismatched = 0;
   int lat;
   logic seen;

   lcm_unit #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .g         (g),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .lcm       (lcm),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic launch(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] gv);
      check({tag, "_rdy_before"}, 32'(in_ready), 32'd1);
      a = av; b = bv; g = gv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_rdy_after"}, 32'(in_ready), 32'd0);
   endtask

   // Counts edges until out_valid; flags any in_ready while busy.
   task automatic wait_out(output int n, output logic rdy_seen);
      n = 0;
      rdy_seen = 1'b0;
      while (out_valid !== 1'b1 && n < 64) begin
         @(posedge clk); #1;
         n++;
         if (in_ready === 1'b1) rdy_seen = 1'b1;
      end
   endtask

   task automatic txn(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] gv, input logic [31:0] exp_lcm,
                      input logic exp_err, input int exp_lat);
      int n;
      logic rs;
      launch(tag, av, bv, gv);
      wait_out(n, rs);
      check({tag, "_latency"}, 32'(n), 32'(exp_lat));
      check({tag, "_busy_rdy"}, 32'(rs), 32'd0);
      check({tag, "_lcm"}, 32'(lcm), exp_lcm);
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0; b = '0; g = '0;
      @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_lcm", 32'(lcm), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      txn("t48_32", 8'd48, 8'd32, 8'd16, 32'd96, 1'b0, 16);
      txn("a0", 8'd0, 8'd5, 8'd5, 32'd0, 1'b0, 1);
      txn("ab0", 8'd0, 8'd0, 8'd0, 32'd0, 1'b0, 1);
      txn("max", 8'd255, 8'd254, 8'd1, 32'd64770, 1'b0, 16);
      txn("g0", 8'd5, 8'd7, 8'd0, 32'd0, 1'b1, 1);
`ifdef LCM_DIVCHECK_EN
      txn("nodiv", 8'd12, 8'd8, 8'd5, 32'd16, 1'b1, 16);
`else
      txn("nodiv", 8'd12, 8'd8, 8'd5, 32'd16, 1'b0, 16);
`endif

      // Backpressure: result must hold, busy input pulses ignored.
      launch("bp", 8'd6, 8'd4, 8'd2);
      wait_out(lat, seen);
      check("bp_latency", 32'(lat), 32'd16);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a = 8'd9; b = 8'd9; g = 8'd9;
         @(posedge clk); #1;
         check("bp_hold_lcm", 32'(lcm), 32'd12);
         check("bp_hold_err", 32'(err), 32'd0);
         check("bp_hold_rdy", 32'(in_ready), 32'd0);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_rdy", 32'(in_ready), 32'd1);
      check("bp_keep_lcm", 32'(lcm), 32'd12);
      repeat (3) @(posedge clk);
      #1;
      check("bp_no_queue_rdy", 32'(in_ready), 32'd1);
      check("bp_no_queue_valid", 32'(out_valid), 32'd0);

      // Reset during the third DIV cycle aborts the operation.
      launch("abort", 8'd48, 8'd32, 8'd16);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_rdy", 32'(in_ready), 32'd1);
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_lcm", 32'(lcm), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      check("abort_no_result", 32'(seen), 32'd0);
      txn("after", 8'd32, 8'd48, 8'd16, 32'd96, 1'b0, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
